// File: rtl/bus_target_if.sv
// CPU bus bundle: a word address every cycle, a write strobe with its data,
// and the read data that comes back one cycle later.
interface bus_target_if;
  // No valid/ready pair on this bus. Every cycle is a transfer: the target
  // samples addrbus/wdata/write_in at each rising edge (a write commits at that
  // edge), and rdata holds the result for the address sampled at the previous
  // edge. The target can never stall.
  logic [31:0] addrbus;
  logic [15:0] wdata;
  logic        write_in;
  logic [15:0] rdata;

  modport master (output addrbus, output wdata, output write_in, input  rdata);
  modport slave  (input  addrbus, input  wdata, input  write_in, output rdata);
endinterface

// File: rtl/bus_target.sv
// Single-cycle-latency CPU bus responder: monitor RAM, a small I/O register
// file (LEDs, cycle counter with snapshot latch, scratch, sticky bus error), SRAM forward.
module bus_target #(
  parameter int          MON_AW   = 12,
  parameter logic [31:0] MON_BASE = 32'hFF000000,
  parameter logic [31:0] IO_BASE  = 32'h30000000,
  parameter logic [31:0] SRAM_TOP = 32'h0003FFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_target_if.slave  bus,
  output logic         sram_we,
  input  logic [15:0]  sram_rdata,
  output logic [15:0]  leds,
  output logic         bus_err
);

  typedef enum logic [1:0] {
    SEL_UNMAP = 2'd0,
    SEL_MON   = 2'd1,
    SEL_IO    = 2'd2,
    SEL_SRAM  = 2'd3
  } sel_e;

  localparam logic [3:0] OFF_LED     = 4'd0;
  localparam logic [3:0] OFF_CTRL    = 4'd1;
  localparam logic [3:0] OFF_LAT_LO  = 4'd2;
  localparam logic [3:0] OFF_LAT_HI  = 4'd3;
  localparam logic [3:0] OFF_STATUS  = 4'd4;
  localparam logic [3:0] OFF_SCRATCH = 4'd5;

  sel_e        sel_d;
  sel_e        sel_q;
  logic        hit_mon;
  logic        hit_io;
  logic        hit_sram;
  logic [3:0]  io_off;
  logic        wr_mon;
  logic        wr_io;
  logic        wr_unmap;
  logic        snap;
  logic        cnt_clr;
  logic        err_clr;
  logic [15:0] io_rd_d;
  logic [15:0] io_q;
  logic [15:0] ram_q;
  logic [15:0] led_q;
  logic [15:0] scratch_q;
  logic [31:0] cnt_q;
  logic [31:0] latch_q;
  logic        err_q;
  logic [MON_AW-1:0] mon_addr;
  logic [15:0] mon_mem [2**MON_AW];

  // Region decode; the regions are disjoint so the priority order is moot.
  assign hit_mon  = (bus.addrbus[31:MON_AW] == MON_BASE[31:MON_AW]);
  assign hit_io   = (bus.addrbus[31:4] == IO_BASE[31:4]);
  assign hit_sram = (bus.addrbus <= SRAM_TOP);
  assign io_off   = bus.addrbus[3:0];
  assign mon_addr = bus.addrbus[MON_AW-1:0];

  always_comb begin
    sel_d = SEL_UNMAP;
    if (hit_mon)       sel_d = SEL_MON;
    else if (hit_io)   sel_d = SEL_IO;
    else if (hit_sram) sel_d = SEL_SRAM;
  end

  assign wr_mon   = bus.write_in && (sel_d == SEL_MON) && rst_n;
  assign wr_io    = bus.write_in && (sel_d == SEL_IO);
  assign wr_unmap = bus.write_in && (sel_d == SEL_UNMAP);
  assign sram_we  = bus.write_in && (sel_d == SEL_SRAM);

  assign snap    = wr_io && (io_off == OFF_CTRL)   && bus.wdata[0];
  assign cnt_clr = wr_io && (io_off == OFF_CTRL)   && bus.wdata[1];
  assign err_clr = wr_io && (io_off == OFF_STATUS) && bus.wdata[0];

  // IO read value is taken from the pre-write register contents.
  always_comb begin
    io_rd_d = 16'h0000;
    if (sel_d == SEL_IO) begin
      case (io_off)
        OFF_LED:     io_rd_d = led_q;
        OFF_LAT_LO:  io_rd_d = latch_q[15:0];
        OFF_LAT_HI:  io_rd_d = latch_q[31:16];
        OFF_STATUS:  io_rd_d = {15'h0000, err_q};
        OFF_SCRATCH: io_rd_d = scratch_q;
        default:     io_rd_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_UNMAP;
      io_q  <= 16'h0000;
    end else begin
      sel_q <= sel_d;
      io_q  <= io_rd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= 16'h0000;
      scratch_q <= 16'h0000;
    end else if (wr_io) begin
      if (io_off == OFF_LED)     led_q     <= bus.wdata;
      if (io_off == OFF_SCRATCH) scratch_q <= bus.wdata;
    end
  end

  // The latch always sees the count from before this edge, so a combined
  // snapshot+clear captures the pre-clear value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 32'h0000_0000;
      latch_q <= 32'h0000_0000;
    end else begin
      cnt_q <= cnt_clr ? 32'h0000_0000 : cnt_q + 32'h0000_0001;
      if (snap) latch_q <= cnt_q;
    end
  end

  // Set beats clear when both happen at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (wr_unmap) err_q <= 1'b1;
    else if (err_clr)  err_q <= 1'b0;
  end

  // Monitor RAM is not reset; write-through on read-during-write.
  always_ff @(posedge clk) begin
    if (wr_mon) mon_mem[mon_addr] <= bus.wdata;
    ram_q <= wr_mon ? bus.wdata : mon_mem[mon_addr];
  end

  always_comb begin
    bus.rdata = 16'h0000;
    case (sel_q)
      SEL_MON:  bus.rdata = ram_q;
      SEL_IO:   bus.rdata = io_q;
      SEL_SRAM: bus.rdata = sram_rdata;
      default:  bus.rdata = 16'h0000;
    endcase
  end

  assign leds    = led_q;
  assign bus_err = err_q;

endmodule

// File: tb/tb_bus_target.sv
// Directed bench for bus_target: a reference model of the address map runs
// alongside the DUT and is compared every cycle; literal checks pin the model.
module tb_bus_target;

  localparam logic [31:0] MON_BASE = 32'hFF000000;
  localparam logic [31:0] IO_BASE  = 32'h30000000;
  localparam logic [31:0] SRAM_TOP = 32'h0003FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sram_we;
  logic [15:0] sram_rdata = 16'h0000;
  logic [15:0] leds;
  logic        bus_err;

  bus_target_if bus ();

  bus_target dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sram_we    (sram_we),
    .sram_rdata (sram_rdata),
    .leds       (leds),
    .bus_err    (bus_err)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_led = '0, m_scr = '0;
  logic [31:0] m_cnt = '0, m_latch = '0;
  logic        m_err = 1'b0;
  logic [15:0] m_mon [bit [31:0]];
  logic [15:0] exp_rd = '0;
  bit          exp_known = 1'b1;
  bit          exp_sram = 1'b0;

  function automatic bit in_mon(input logic [31:0] a);
    return (a >= MON_BASE) && ((a - MON_BASE) < 32'd4096);
  endfunction
  function automatic bit in_io(input logic [31:0] a);
    return (a >= IO_BASE) && (a < IO_BASE + 32'd16);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_led = '0; m_scr = '0; m_cnt = '0; m_latch = '0; m_err = 1'b0;
        exp_rd = '0; exp_known = 1'b1; exp_sram = 1'b0;
      end else begin
        logic [31:0] a, off, old_cnt;
        logic [15:0] wd;
        logic        wr, clr;
        a = bus.addrbus; wd = bus.wdata; wr = bus.write_in;
        old_cnt = m_cnt; clr = 1'b0;
        exp_rd = '0; exp_known = 1'b1; exp_sram = 1'b0;
        if (in_mon(a)) begin
          if (wr) m_mon[a] = wd;
          exp_known = m_mon.exists(a);
          if (exp_known) exp_rd = m_mon[a];
        end else if (in_io(a)) begin
          off = a - IO_BASE;
          case (off)
            0: exp_rd = m_led;
            2: exp_rd = m_latch[15:0];
            3: exp_rd = m_latch[31:16];
            4: exp_rd = {15'd0, m_err};
            5: exp_rd = m_scr;
            default: exp_rd = '0;
          endcase
          if (wr) begin
            case (off)
              0: m_led = wd;
              1: begin
                if (wd[0]) m_latch = old_cnt;
                clr = wd[1];
              end
              4: if (wd[0]) m_err = 1'b0;
              5: m_scr = wd;
              default: ;
            endcase
          end
        end else if (a <= SRAM_TOP) begin
          exp_sram = 1'b1;
        end else if (wr) begin
          m_err = 1'b1;
        end
        m_cnt = clr ? 32'd0 : old_cnt + 32'd1;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && rst_n) begin
        if (exp_sram)       chk("rdata_sram", {16'd0, bus.rdata}, {16'd0, sram_rdata});
        else if (exp_known) chk("rdata", {16'd0, bus.rdata}, {16'd0, exp_rd});
        chk("leds", {16'd0, leds}, {16'd0, m_led});
        chk("bus_err", {31'd0, bus_err}, {31'd0, m_err});
        chk("sram_we", {31'd0, sram_we},
            {31'd0, bus.write_in && (bus.addrbus <= SRAM_TOP)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives one bus cycle and returns at the next posedge+1.
  task automatic cyc(input logic [31:0] a, input logic [15:0] d, input logic w);
    bus.addrbus  = a;
    bus.wdata    = d;
    bus.write_in = w;
    @(posedge clk);
    #1;
    bus.write_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(MON_BASE, 16'h0000, 1'b0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [15:0] e);
    cyc(a, 16'h0000, 1'b0);
    chk(name, {16'd0, bus.rdata}, {16'd0, e});
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.addrbus = MON_BASE; bus.wdata = '0; bus.write_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("reset_rdata", {16'd0, bus.rdata}, 32'h0);
    chk("reset_leds", {16'd0, leds}, 32'h0);
    chk("reset_bus_err", {31'd0, bus_err}, 32'h0);

    // Counter snapshot: 100 cycles, then latch, then snapshot+clear.
    idle(100);
    cyc(IO_BASE + 1, 16'h0001, 1'b1);
    rd_chk("latch_lo_100", IO_BASE + 2, 16'h0064);
    rd_chk("latch_hi_100", IO_BASE + 3, 16'h0000);
    idle(5);
    rd_chk("latch_lo_stable", IO_BASE + 2, 16'h0064);
    cyc(IO_BASE + 1, 16'h0003, 1'b1);
    rd_chk("latch_preclear", IO_BASE + 2, 16'h006D);
    cyc(IO_BASE + 1, 16'h0001, 1'b1);
    rd_chk("latch_after_clear", IO_BASE + 2, 16'h0001);
    rd_chk("ctrl_reads_0", IO_BASE + 1, 16'h0000);

    // Monitor memory.
    cyc(MON_BASE + 5, 16'h1234, 1'b1);
    rd_chk("mon_readback", MON_BASE + 5, 16'h1234);
    cyc(MON_BASE + 6, 16'hBEEF, 1'b1);
    chk("mon_write_through", {16'd0, bus.rdata}, 32'h0000BEEF);
    rd_chk("mon_top_word_prev", MON_BASE + 6, 16'hBEEF);
    cyc(MON_BASE + 32'hFFF, 16'hC0DE, 1'b1);
    rd_chk("mon_top_word", MON_BASE + 32'hFFF, 16'hC0DE);

    // LED and scratch.
    cyc(IO_BASE + 0, 16'hA5A5, 1'b1);
    cyc(IO_BASE + 5, 16'h5A5A, 1'b1);
    rd_chk("led_readback", IO_BASE + 0, 16'hA5A5);
    chk("leds_out", {16'd0, leds}, 32'h0000A5A5);
    rd_chk("scratch_readback", IO_BASE + 5, 16'h5A5A);
    cyc(IO_BASE + 9, 16'hFFFF, 1'b1);
    rd_chk("io_hole_reads_0", IO_BASE + 9, 16'h0000);
    chk("io_hole_no_err", {31'd0, bus_err}, 32'h0);

    // Unmapped region and sticky error.
    rd_chk("unmapped_read", 32'h20000000, 16'h0000);
    chk("unmapped_read_no_err", {31'd0, bus_err}, 32'h0);
    cyc(32'h20000000, 16'h1111, 1'b1);
    chk("unmapped_write_err", {31'd0, bus_err}, 32'h1);
    rd_chk("status_reads_err", IO_BASE + 4, 16'h0001);
    cyc(32'h20000004, 16'h2222, 1'b1);
    cyc(IO_BASE + 4, 16'h0001, 1'b1);
    chk("status_clear", {31'd0, bus_err}, 32'h0);

    // SRAM forward.
    cyc(SRAM_TOP, 16'h0000, 1'b0);
    sram_rdata = 16'h7777;
    #1 chk("sram_read", {16'd0, bus.rdata}, 32'h00007777);
    bus.addrbus = SRAM_TOP; bus.write_in = 1'b1; bus.wdata = 16'h9999;
    #1 chk("sram_we_top", {31'd0, sram_we}, 32'h1);
    bus.addrbus = SRAM_TOP + 1;
    #1 chk("sram_we_beyond", {31'd0, sram_we}, 32'h0);
    bus.addrbus = SRAM_TOP;
    @(posedge clk); #1;
    bus.write_in = 1'b0;
    sram_rdata = 16'h1357;
    cyc(32'h00000000, 16'h0000, 1'b0);
    #1 chk("sram_read_low", {16'd0, bus.rdata}, 32'h00001357);

    // Asynchronous reset in the middle of a cycle.
    cyc(32'h20000000, 16'h0000, 1'b1);
    cyc(IO_BASE + 0, 16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rdata", {16'd0, bus.rdata}, 32'h0);
    chk("midreset_leds", {16'd0, leds}, 32'h0);
    chk("midreset_bus_err", {31'd0, bus_err}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
